// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures decoded control and WB-bypassed operands, inserts a
// one-cycle bubble on load-use hazards, and honours branch flush and downstream EX stall.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter logic [2:0]  ALU_NOP  = 3'b000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [2:0]        id_alu_cntrl,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [DATA_W-1:0] id_rn_data,
    input  logic [DATA_W-1:0] id_rm_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_set_flags,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [2:0]        ex_alu_cntrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_set_flags,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    // Flow control: an instruction moves ID->EX on an edge where ex_stall is low and no
    // hazard is seen; id_stall tells IF/ID to hold its instruction for that same edge.
    logic              hazard;
    logic              capture;
    logic              bubble;
    logic [DATA_W-1:0] rn_v;
    logic [DATA_W-1:0] rm_v;

    always_comb begin
        hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != ZR) &
                 ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
        rn_v = (wb_reg_write && (wb_rd == id_rn) && (id_rn != ZR)) ? wb_data : id_rn_data;
        rm_v = (wb_reg_write && (wb_rd == id_rm) && (id_rm != ZR)) ? wb_data : id_rm_data;
        capture = ~ex_stall & id_valid & ~hazard;
        // flush beats ex_stall; otherwise a non-stalled edge that does not capture loads a bubble
        bubble  = flush | (~ex_stall & ~capture);
    end

    assign id_stall = hazard | ex_stall;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_valid      <= 1'b0;
            ex_alu_cntrl  <= ALU_NOP;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_set_flags  <= 1'b0;
        end else if (capture) begin
            ex_valid      <= 1'b1;
            ex_alu_cntrl  <= id_alu_cntrl;
            ex_a          <= rn_v;
            ex_b          <= id_alu_src ? id_imm : rm_v;
            ex_store_data <= rm_v;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_set_flags  <= id_set_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!flush && !ex_stall && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
